// File: rtl/ipsxe_floating_point_fma_result_buffer_v1_0_pkg.sv
// Shared constants and helpers for the FMA result buffer: flag bit positions
// within the {invalid_op, underflow, overflow} field, and the statistics counter width.
package ipsxe_floating_point_fma_result_buffer_v1_0_pkg;

  localparam int FLAG_W         = 3;
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 0;

  localparam int STATS_W = 16;

  // Saturating increment used by the per-flag statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] value,
                                                 input logic               en);
    if (en && (value != {STATS_W{1'b1}})) begin
      return value + STATS_W'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_sync_fifo_v1_0.sv
// First-word-fall-through synchronous FIFO exposing its occupancy.
// A push while full without a same-cycle pop is discarded.
module ipsxe_floating_point_sync_fifo_v1_0 #(
  parameter  int WIDTH = 35,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign rdata = mem[rd_ptr];

  // NOTE: the storage array has no reset; count and pointers alone define validity,
  // so resetting the array would only add a wide reset network for no benefit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_fma_result_buffer_v1_0.sv
// Credit-based valid/ready result buffer behind the fixed-latency FMA core.
// Optional per-flag pop statistics enabled by `IPSXE_FMA_RESULT_BUF_STATS_EN.
module ipsxe_floating_point_fma_result_buffer_v1_0
  import ipsxe_floating_point_fma_result_buffer_v1_0_pkg::*;
#(
  parameter  int EXP_WIDTH = 8,
  parameter  int MAN_WIDTH = 23,
  parameter  int DEPTH     = 16,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int DATA_W    = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_aclken,
  input  logic               i_issue_valid,
  output logic               o_issue_ready,
  input  logic [DATA_W-1:0]  i_fma_result,
  input  logic               i_fma_valid,
  input  logic [FLAG_W-1:0]  i_fma_flags,
  output logic [DATA_W-1:0]  o_m_tdata,
  output logic [FLAG_W-1:0]  o_m_tuser,
  output logic               o_m_tvalid,
  input  logic               i_m_tready,
`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
  output logic [STATS_W-1:0] o_cnt_invalid,
  output logic [STATS_W-1:0] o_cnt_underflow,
  output logic [STATS_W-1:0] o_cnt_overflow,
`endif
  output logic               o_err_overrun,
  output logic               o_err_orphan
);

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W:0]   credits_used;
  logic             issue;
  logic             push;
  logic             pop;

  assign issue = i_issue_valid & o_issue_ready & i_aclken;
  assign push  = i_fma_valid & i_aclken;
  assign pop   = o_m_tvalid & i_m_tready;

  // Every issued operand set owns a slot, so credits cover both in-flight and buffered results.
  assign credits_used  = {1'b0, inflight} + {1'b0, fifo_count};
  assign o_issue_ready = credits_used < (CNT_W + 1)'(DEPTH);
  assign o_m_tvalid    = ~fifo_empty;

  ipsxe_floating_point_sync_fifo_v1_0 #(
    .WIDTH (DATA_W + FLAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata ({i_fma_result, i_fma_flags}),
    .rdata ({o_m_tdata, o_m_tuser}),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else if (issue && !push) begin
      inflight <= inflight + CNT_W'(1);
    end else if (push && !issue && (inflight != '0)) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_overrun <= 1'b0;
      o_err_orphan  <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) o_err_overrun <= 1'b1;
      if (push && (inflight == '0))  o_err_orphan  <= 1'b1;
    end
  end

`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_invalid   <= '0;
      o_cnt_underflow <= '0;
      o_cnt_overflow  <= '0;
    end else begin
      o_cnt_invalid   <= sat_inc(o_cnt_invalid,   pop & o_m_tuser[FLAG_INVALID]);
      o_cnt_underflow <= sat_inc(o_cnt_underflow, pop & o_m_tuser[FLAG_UNDERFLOW]);
      o_cnt_overflow  <= sat_inc(o_cnt_overflow,  pop & o_m_tuser[FLAG_OVERFLOW]);
    end
  end
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_fma_result_buffer_v1_0.sv
// Randomized self-checking bench: a queue-based model of the credit/buffer contract
// is stepped every cycle alongside directed scenarios.
module tb_ipsxe_floating_point_fma_result_buffer_v1_0;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int FW    = 3;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_aclken;
  logic          i_issue_valid;
  logic          o_issue_ready;
  logic [DW-1:0] i_fma_result;
  logic          i_fma_valid;
  logic [FW-1:0] i_fma_flags;
  logic [DW-1:0] o_m_tdata;
  logic [FW-1:0] o_m_tuser;
  logic          o_m_tvalid;
  logic          i_m_tready;
  logic          o_err_overrun;
  logic          o_err_orphan;
`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
  logic [15:0]   o_cnt_invalid;
  logic [15:0]   o_cnt_underflow;
  logic [15:0]   o_cnt_overflow;
`endif

  always #5 i_clk = ~i_clk;

  ipsxe_floating_point_fma_result_buffer_v1_0 dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_aclken        (i_aclken),
    .i_issue_valid   (i_issue_valid),
    .o_issue_ready   (o_issue_ready),
    .i_fma_result    (i_fma_result),
    .i_fma_valid     (i_fma_valid),
    .i_fma_flags     (i_fma_flags),
    .o_m_tdata       (o_m_tdata),
    .o_m_tuser       (o_m_tuser),
    .o_m_tvalid      (o_m_tvalid),
    .i_m_tready      (i_m_tready),
`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
    .o_cnt_invalid   (o_cnt_invalid),
    .o_cnt_underflow (o_cnt_underflow),
    .o_cnt_overflow  (o_cnt_overflow),
`endif
    .o_err_overrun   (o_err_overrun),
    .o_err_orphan    (o_err_orphan)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: results waiting to be consumed, launched-but-not-returned count.
  logic [DW+FW-1:0] m_q[$];
  int               m_inflight;
  bit               m_overrun;
  bit               m_orphan;
  bit               chk_en;
  int               m_ci, m_cu, m_co;

  task automatic drive_idle();
    i_aclken      = 1'b1;
    i_issue_valid = 1'b0;
    i_fma_valid   = 1'b0;
    i_fma_result  = '0;
    i_fma_flags   = '0;
    i_m_tready    = 1'b0;
  endtask

  // Compare DUT against the model, advance the model by one clock, then advance the DUT.
  task automatic step();
    bit   ready_m, issue, push, pop, was_full;
    logic [DW+FW-1:0] head;
    if (chk_en) begin
      n_vec++;
      if (o_m_tvalid !== (m_q.size() != 0)) begin
        n_err++; $display("FAIL tvalid @%0t: got %b want %b", $time, o_m_tvalid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        head = m_q[0];
        n_vec++;
        if ({o_m_tdata, o_m_tuser} !== head) begin
          n_err++; $display("FAIL head @%0t: got %h/%b want %h/%b", $time, o_m_tdata, o_m_tuser,
                            head[DW+FW-1:FW], head[FW-1:0]);
        end
      end
      n_vec++;
      if (o_issue_ready !== ((m_inflight + m_q.size()) < DEPTH)) begin
        n_err++; $display("FAIL issue_ready @%0t: got %b want %b", $time, o_issue_ready,
                          (m_inflight + m_q.size()) < DEPTH);
      end
      n_vec++;
      if ({o_err_overrun, o_err_orphan} !== {m_overrun, m_orphan}) begin
        n_err++; $display("FAIL err_flags @%0t: got %b%b want %b%b", $time, o_err_overrun,
                          o_err_orphan, m_overrun, m_orphan);
      end
`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
      n_vec++;
      if ({o_cnt_invalid, o_cnt_underflow, o_cnt_overflow} !== {16'(m_ci), 16'(m_cu), 16'(m_co)}) begin
        n_err++; $display("FAIL stats @%0t: got %0d/%0d/%0d want %0d/%0d/%0d", $time, o_cnt_invalid,
                          o_cnt_underflow, o_cnt_overflow, m_ci, m_cu, m_co);
      end
`endif
    end
    if (i_rst) begin
      m_q.delete();
      m_inflight = 0; m_overrun = 0; m_orphan = 0;
      m_ci = 0; m_cu = 0; m_co = 0;
    end else begin
      ready_m  = (m_inflight + m_q.size()) < DEPTH;
      issue    = i_issue_valid && ready_m && i_aclken;
      push     = i_fma_valid && i_aclken;
      pop      = (m_q.size() != 0) && i_m_tready;
      was_full = (m_q.size() == DEPTH);
      if (push && m_inflight == 0) m_orphan = 1;
      if (pop) begin
        head = m_q.pop_front();
        if (head[2] && m_ci < 65535) m_ci++;
        if (head[1] && m_cu < 65535) m_cu++;
        if (head[0] && m_co < 65535) m_co++;
      end
      if (push) begin
        if (was_full && !pop) m_overrun = 1;
        else m_q.push_back({i_fma_result, i_fma_flags});
      end
      if (issue && !push) m_inflight++;
      else if (push && !issue && m_inflight > 0) m_inflight--;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    chk_en = 0;
    i_rst  = 1'b1;
    step();
    step();
    i_rst  = 1'b0;
    chk_en = 1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [FW-1:0] f);
    i_fma_valid = 1'b1; i_fma_result = d; i_fma_flags = f;
    step();
    i_fma_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({o_issue_ready, o_m_tvalid, o_err_overrun, o_err_orphan} !== 4'b1000) begin
      n_err++; $display("FAIL reset_state: got %b%b%b%b want 1000", o_issue_ready, o_m_tvalid,
                        o_err_overrun, o_err_orphan);
    end
    i_issue_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    i_issue_valid = 1'b0;
    n_vec++;
    if (o_issue_ready !== 1'b0) begin
      n_err++; $display("FAIL credits_exhausted: got ready %b want 0", o_issue_ready);
    end
  endtask

  task automatic test_latency();
    do_reset();
    i_issue_valid = 1'b1; step(); i_issue_valid = 1'b0;
    for (int i = 1; i < 14; i++) step();
    push_word(32'h3F80_0000, 3'b000);
    i_m_tready = 1'b1;
    n_vec++;
    if (o_m_tvalid !== 1'b1 || o_m_tdata !== 32'h3F80_0000) begin
      n_err++; $display("FAIL first_result: got %b/%h want 1/3f800000", o_m_tvalid, o_m_tdata);
    end
    step();
    i_m_tready = 1'b0;
    n_vec++;
    if (o_m_tvalid !== 1'b0) begin
      n_err++; $display("FAIL after_pop: got tvalid %b want 0", o_m_tvalid);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    push_word(32'hDEAD_BEEF, 3'b101);
    n_vec++;
    if (o_err_orphan !== 1'b1 || o_m_tvalid !== 1'b1 || o_m_tdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL orphan: got flag %b tvalid %b data %h want 1 1 deadbeef",
                        o_err_orphan, o_m_tvalid, o_m_tdata);
    end
    i_m_tready = 1'b1; step(); i_m_tready = 1'b0;
    step();
    n_vec++;
    if (o_err_orphan !== 1'b1) begin
      n_err++; $display("FAIL orphan_sticky: got %b want 1", o_err_orphan);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    i_issue_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    i_issue_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word($urandom, 3'($urandom_range(0, 7)));
    n_vec++;
    if (o_issue_ready !== 1'b0 || o_m_tvalid !== 1'b1) begin
      n_err++; $display("FAIL full_state: got ready %b tvalid %b want 0 1", o_issue_ready, o_m_tvalid);
    end
    i_m_tready = 1'b1;
    push_word(32'h1234_5678, 3'b010);
    i_m_tready = 1'b0;
    n_vec++;
    if (o_err_overrun !== 1'b0) begin
      n_err++; $display("FAIL full_push_pop: got overrun %b want 0", o_err_overrun);
    end
    push_word(32'h8765_4321, 3'b001);
    n_vec++;
    if (o_err_overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun: got %b want 1", o_err_overrun);
    end
    i_m_tready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    i_m_tready = 1'b0;
    n_vec++;
    if (o_err_overrun !== 1'b1 || o_m_tvalid !== 1'b0) begin
      n_err++; $display("FAIL overrun_sticky: got overrun %b tvalid %b want 1 0", o_err_overrun, o_m_tvalid);
    end
  endtask

  task automatic test_aclken();
    do_reset();
    i_issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    i_issue_valid = 1'b0;
    push_word(32'h0000_0001, 3'b000);
    push_word(32'h0000_0002, 3'b000);
    i_aclken = 1'b0; i_issue_valid = 1'b1; i_fma_valid = 1'b1; i_m_tready = 1'b1;
    i_fma_result = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) step();
    drive_idle();
    n_vec++;
    if (o_m_tvalid !== 1'b0 || o_issue_ready !== 1'b1 || o_err_orphan !== 1'b0) begin
      n_err++; $display("FAIL aclken_hold: got tvalid %b ready %b orphan %b want 0 1 0",
                        o_m_tvalid, o_issue_ready, o_err_orphan);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      i_aclken      = ($urandom_range(0, 9) != 0);
      i_issue_valid = $urandom_range(0, 1);
      i_fma_valid   = (m_inflight > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      i_fma_result  = $urandom;
      i_fma_flags   = 3'($urandom_range(0, 7));
      i_m_tready    = ($urandom_range(0, 3) != 0) ^ (i >= 200 && i < 260);
      i_rst         = (i == 400);
      step();
    end
    i_rst = 1'b0;
    drive_idle();
  endtask

`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
  task automatic test_stats();
    do_reset();
    i_issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    i_issue_valid = 1'b0;
    push_word(32'hA, 3'b100);
    push_word(32'hB, 3'b011);
    push_word(32'hC, 3'b001);
    i_m_tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    i_m_tready = 1'b0;
    n_vec++;
    if (o_cnt_invalid !== 16'd1 || o_cnt_underflow !== 16'd1 || o_cnt_overflow !== 16'd2) begin
      n_err++; $display("FAIL stats_counts: got %0d/%0d/%0d want 1/1/2", o_cnt_invalid,
                        o_cnt_underflow, o_cnt_overflow);
    end
  endtask
`endif

  initial begin
    drive_idle();
    i_rst  = 1'b1;
    chk_en = 0;
    m_inflight = 0; m_overrun = 0; m_orphan = 0;
    m_ci = 0; m_cu = 0; m_co = 0;
    #1;
    test_reset();
    test_latency();
    test_orphan();
    test_full_push_pop();
    test_aclken();
    test_random();
`ifdef IPSXE_FMA_RESULT_BUF_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
